// File: rtl/lsq_partition_cfg_ctrl_pkg.sv
// Shared types and helpers for the LSQ partition reconfiguration controller.
// Holds the geometry of the partitioned following-load RAM, the controller
// state encoding, the mask legality check and the partition base address.
package lsq_cfg_pkg;

  localparam int NUM_PARTS     = 4;
  localparam int DEPTH         = 32;
  localparam int INDEX         = 5;
  localparam int WIDTH         = 8;
  localparam int SETTLE_CYCLES = 4;
  localparam int PART_DEPTH    = DEPTH / NUM_PARTS;
  // Settle counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    POWER = 2'd2,
    CLEAR = 2'd3
  } lsq_cfg_state_t;

  // Legal masks are nonzero thermometer codes: partitions 0..k-1 active.
  function automatic logic mask_legal(input logic [NUM_PARTS-1:0] m);
    logic [NUM_PARTS-1:0] m_plus;
    m_plus = m + NUM_PARTS'(1);
    return (m != '0) && ((m & m_plus) == '0);
  endfunction

  // First RAM entry of partition p.
  function automatic logic [INDEX-1:0] part_base(input int p);
    return INDEX'(p * PART_DEPTH);
  endfunction

endpackage

// File: rtl/lsq_partition_cfg_ctrl_if.sv
// Request/status handshake between the dynamic-config unit (master) and the
// partition reconfiguration controller (slave).
interface lsq_partition_cfg_ctrl_if;
  import lsq_cfg_pkg::*;

  logic                 cfgReq_i;
  logic [NUM_PARTS-1:0] cfgPartMask_i;
  logic                 cfgBusy_o;
  logic                 cfgDone_o;
  logic                 cfgError_o;

  modport slave  (input  cfgReq_i, cfgPartMask_i,
                  output cfgBusy_o, cfgDone_o, cfgError_o);
  modport master (output cfgReq_i, cfgPartMask_i,
                  input  cfgBusy_o, cfgDone_o, cfgError_o);
endinterface

// File: rtl/lsq_partition_cfg_ctrl_walker.sv
// lsq_part_scrub_walker: walks the RAM addresses of the partitions set in
// en_mask in ascending order, one address per step, skipping partitions that
// are not set. Only built when LSQ_PART_SCRUB_EN is defined.
// Out of reset it is armed at address 0, so the post-reset scrub of the whole
// RAM needs no start pulse (the controller holds an all-ones mask then).
module lsq_part_scrub_walker
  import lsq_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic [NUM_PARTS-1:0] en_mask,
  output logic [INDEX-1:0]     addr,
  output logic                 we,
  output logic                 last
);

  logic [INDEX-1:0] addr_r;
  logic             active_r;
  int               cur_part_s;
  int               next_part_s;
  int               first_part_s;
  logic             have_next_s;
  logic             have_first_s;
  logic             at_end_s;

  // Locate the current partition and the next/first enabled partitions.
  always_comb begin
    cur_part_s   = int'(addr_r) / PART_DEPTH;
    at_end_s     = ((int'(addr_r) % PART_DEPTH) == (PART_DEPTH - 1));
    next_part_s  = 0;
    first_part_s = 0;
    have_next_s  = 1'b0;
    have_first_s = 1'b0;
    // Descending scan so the lowest qualifying partition wins.
    for (int p = NUM_PARTS - 1; p >= 0; p--) begin
      next_part_s  = (en_mask[p] && (p > cur_part_s)) ? p : next_part_s;
      have_next_s  = (en_mask[p] && (p > cur_part_s)) ? 1'b1 : have_next_s;
      first_part_s = en_mask[p] ? p : first_part_s;
      have_first_s = en_mask[p] ? 1'b1 : have_first_s;
    end
  end

  // Address walk: load on start, advance on step, stop (no wrap) after the last entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r   <= '0;
      active_r <= 1'b1;
    end else if (start) begin
      addr_r   <= have_first_s ? part_base(first_part_s) : '0;
      active_r <= have_first_s;
    end else if (step && active_r) begin
      if (at_end_s) begin
        if (have_next_s) begin
          addr_r <= part_base(next_part_s);
        end else begin
          active_r <= 1'b0;
        end
      end else begin
        addr_r <= addr_r + INDEX'(1);
      end
    end
  end

  assign addr = addr_r;
  assign we   = active_r;
  assign last = active_r && at_end_s && !have_next_s;

endmodule

// File: rtl/lsq_partition_cfg_ctrl.sv
// lsq_partition_cfg_ctrl: sequences LSQ partition reconfiguration.
// IDLE -> DRAIN (wait for empty LSQ) -> POWER (apply mask, wait settle)
// -> CLEAR (scrub newly enabled partitions) -> IDLE with a done pulse.
// Optional feature macro: LSQ_PART_SCRUB_EN. When undefined there is no
// CLEAR phase, no post-reset scrub, and the scrub port outputs are tied 0.
module lsq_partition_cfg_ctrl
  import lsq_cfg_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  lsq_partition_cfg_ctrl_if.slave    cfg,
  input  logic                       lsqEmpty_i,
  output logic [NUM_PARTS-1:0]       lsqPartitionActive_o,
  output logic                       dispatchStall_o,
  output logic                       clrActive_o,
  output logic                       clrWe_o,
  output logic [INDEX-1:0]           clrAddr_o,
  output logic [WIDTH-1:0]           clrData_o,
  output logic                       ldqRamReady_o
);

  lsq_cfg_state_t       state_r, state_s;
  logic [NUM_PARTS-1:0] mask_r, mask_s;
  logic [NUM_PARTS-1:0] pend_r, pend_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 stall_r, stall_s;
  logic                 ready_r, ready_s;
  logic                 done_r, done_s;
  logic                 error_r, error_s;
  logic                 busy_r, busy_s;

`ifdef LSQ_PART_SCRUB_EN
  logic [NUM_PARTS-1:0] scrub_r, scrub_s;
  logic                 clr_active_r, clr_active_s;
  logic                 clr_we_r, clr_we_s;
  logic [INDEX-1:0]     clr_addr_r, clr_addr_s;
  logic                 last_wr_r, last_wr_s;
  logic                 walk_start_s, walk_step_s;
  logic [INDEX-1:0]     walk_addr_s;
  logic                 walk_we_s, walk_last_s;

  lsq_part_scrub_walker u_walker (
    .clk     (clk),
    .reset   (reset),
    .start   (walk_start_s),
    .step    (walk_step_s),
    .en_mask (scrub_r),
    .addr    (walk_addr_s),
    .we      (walk_we_s),
    .last    (walk_last_s)
  );
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s = state_r;
    mask_s  = mask_r;
    pend_s  = pend_r;
    cnt_s   = cnt_r;
    stall_s = stall_r;
    ready_s = ready_r;
    done_s  = 1'b0;
    error_s = 1'b0;
`ifdef LSQ_PART_SCRUB_EN
    scrub_s      = scrub_r;
    clr_active_s = 1'b0;
    clr_we_s     = 1'b0;
    clr_addr_s   = clr_addr_r;
    last_wr_s    = 1'b0;
    walk_start_s = 1'b0;
    walk_step_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        stall_s = 1'b0;
        ready_s = 1'b1;
        if (cfg.cfgReq_i) begin
          if (!mask_legal(cfg.cfgPartMask_i)) begin
            error_s = 1'b1;
          end else if (cfg.cfgPartMask_i == mask_r) begin
            done_s = 1'b1;
          end else begin
            state_s = DRAIN;
            pend_s  = cfg.cfgPartMask_i;
            stall_s = 1'b1;
`ifdef LSQ_PART_SCRUB_EN
            scrub_s = cfg.cfgPartMask_i & ~mask_r;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        stall_s = 1'b1;
`ifdef LSQ_PART_SCRUB_EN
        // Arm the walker early so the first write can issue as POWER ends.
        walk_start_s = 1'b1;
`endif
        if (lsqEmpty_i) begin
          state_s = POWER;
          mask_s  = pend_r;
          ready_s = 1'b0;
          cnt_s   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          state_s = DRAIN;
        end
      end
      POWER: begin
        stall_s = 1'b1;
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
`ifdef LSQ_PART_SCRUB_EN
        end else if (scrub_r != '0) begin
          state_s      = CLEAR;
          clr_active_s = 1'b1;
          clr_we_s     = walk_we_s;
          clr_addr_s   = walk_addr_s;
          walk_step_s  = 1'b1;
          last_wr_s    = walk_last_s;
`endif
        end else begin
          state_s = IDLE;
          done_s  = 1'b1;
          ready_s = 1'b1;
          stall_s = 1'b0;
        end
      end
`ifdef LSQ_PART_SCRUB_EN
      CLEAR: begin
        stall_s = 1'b1;
        if (last_wr_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
          ready_s = 1'b1;
          stall_s = 1'b0;
        end else begin
          clr_active_s = 1'b1;
          clr_we_s     = walk_we_s;
          clr_addr_s   = walk_addr_s;
          walk_step_s  = 1'b1;
          last_wr_s    = walk_last_s;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_r  <= '1;
      pend_r  <= '1;
      cnt_r   <= '0;
      stall_r <= 1'b1;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
`ifdef LSQ_PART_SCRUB_EN
      state_r      <= CLEAR;
      busy_r       <= 1'b1;
      scrub_r      <= '1;
      clr_active_r <= 1'b1;
      clr_we_r     <= 1'b0;
      clr_addr_r   <= '0;
      last_wr_r    <= 1'b0;
`else
      state_r      <= IDLE;
      busy_r       <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      mask_r  <= mask_s;
      pend_r  <= pend_s;
      cnt_r   <= cnt_s;
      stall_r <= stall_s;
      ready_r <= ready_s;
      done_r  <= done_s;
      error_r <= error_s;
      busy_r  <= busy_s;
`ifdef LSQ_PART_SCRUB_EN
      scrub_r      <= scrub_s;
      clr_active_r <= clr_active_s;
      clr_we_r     <= clr_we_s;
      clr_addr_r   <= clr_addr_s;
      last_wr_r    <= last_wr_s;
`endif
    end
  end

  assign lsqPartitionActive_o = mask_r;
  assign dispatchStall_o      = stall_r;
  assign ldqRamReady_o        = ready_r;
  assign clrData_o            = '0;
  assign cfg.cfgBusy_o        = busy_r;
  assign cfg.cfgDone_o        = done_r;
  assign cfg.cfgError_o       = error_r;
`ifdef LSQ_PART_SCRUB_EN
  assign clrActive_o = clr_active_r;
  assign clrWe_o     = clr_we_r;
  assign clrAddr_o   = clr_addr_r;
`else
  assign clrActive_o = 1'b0;
  assign clrWe_o     = 1'b0;
  assign clrAddr_o   = '0;
`endif

endmodule
